alu_cmd_fifo: RTL and testbench

//  Command buffer directly upstream of the 4-bit alu: queues {ALUOp,A,B} triples and presents the head entry on
//  alu_a/alu_b/alu_op, with a valid/ready handshake on both sides. Lets a producer issue bursts of ALU commands

---
 rtl/alu_cmd_fifo_pkg.sv | 15 +
 rtl/alu_cmd_fifo.sv | 103 ++++++++++
 tb/tb_alu_cmd_fifo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_fifo_pkg.sv
// rtl/alu_cmd_fifo_pkg.sv - shared ALU widths and ALUOp encodings for the command FIFO
package alu_cmd_fifo_pkg;

    localparam int ALU_DW  = 4;
    localparam int ALU_OPW = 2;

    // Encodings are owned by the alu; the FIFO carries them opaquely.
    typedef enum logic [ALU_OPW-1:0] {
        ALU_OP_0 = 2'b00,
        ALU_OP_1 = 2'b01,
        ALU_OP_2 = 2'b10,
        ALU_OP_3 = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - show-ahead {op,a,b} command queue feeding the alu
// Optional combinational empty-bypass path enabled by defining ALU_CMD_BYPASS_EN.
module alu_cmd_fifo
    import alu_cmd_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = ALU_DW,
    parameter int OPW   = ALU_OPW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW-1:0]              in_a,
    input  logic [DW-1:0]              in_b,
    input  logic [OPW-1:0]             in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              alu_a,
    output logic [DW-1:0]              alu_b,
    output logic [OPW-1:0]             alu_op,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = OPW + 2*DW;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [EW-1:0] head;
    logic          empty;
    logic          full;
    logic          wr_en;
    logic          rd_en;
    logic          bypass;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign in_ready = !full;
    assign head     = mem[rd_ptr];
    assign rd_en    = !empty && out_ready;

`ifdef ALU_CMD_BYPASS_EN
    // An empty queue forwards the producer straight through; it is only
    // written if the consumer does not take it this cycle.
    assign bypass    = empty && in_valid && !flush;
    assign wr_en     = in_valid && in_ready && !flush && !(bypass && out_ready);
    assign out_valid = !empty || bypass;
`else
    assign bypass    = 1'b0;
    assign wr_en     = in_valid && in_ready && !flush;
    assign out_valid = !empty;
`endif

    always_comb begin
        alu_op = '0;
        alu_a  = '0;
        alu_b  = '0;
        if (bypass) begin
            alu_op = in_op;
            alu_a  = in_a;
            alu_b  = in_b;
        end else if (!empty) begin
            alu_op = head[EW-1 -: OPW];
            alu_a  = head[2*DW-1 -: DW];
            alu_b  = head[DW-1:0];
        end
    end

    // Storage is intentionally left uninitialised on reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[wr_ptr] <= {in_op, in_a, in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !rd_en) begin
                count <= count + CW'(1);
            end else if (rd_en && !wr_en) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_fifo.sv
// tb/tb_alu_cmd_fifo.sv - directed self-checking bench for alu_cmd_fifo
module tb_alu_cmd_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [1:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic [2:0] count;

    int passed = 0;
    int total  = 0;

    alu_cmd_fifo #(.DEPTH(4), .DW(4), .OPW(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 4'd5, 4'd6, 2'd1);
        tick; tick;
        total++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        total++; if ({alu_op, alu_a, alu_b} !== 10'd0) $display("FAIL reset_alu got %h want 0", {alu_op, alu_a, alu_b}); else passed++;
        reset = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 2'd0);
        tick;
        total++; if (count !== 3'd0) $display("FAIL reset_release_count got %0d want 0", count); else passed++;
    endtask

    task automatic test_single;
        out_ready = 1'b0;
        drive(1'b1, 4'b1001, 4'b0001, 2'b00);
        tick;
        drive(1'b0, 4'd0, 4'd0, 2'd0);
        total++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b want 1", out_valid); else passed++;
        total++; if (alu_a !== 4'd9 || alu_b !== 4'd1 || alu_op !== 2'd0)
            $display("FAIL single_data got a=%0d b=%0d op=%0d want a=9 b=1 op=0", alu_a, alu_b, alu_op); else passed++;
        total++; if (count !== 3'd1) $display("FAIL single_count got %0d want 1", count); else passed++;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        total++; if (count !== 3'd0 || out_valid !== 1'b0 || alu_a !== 4'd0)
            $display("FAIL single_drain got count=%0d valid=%b a=%0d want 0/0/0", count, out_valid, alu_a); else passed++;
    endtask

    task automatic test_fill;
        logic [3:0] ea [4] = '{4'd7, 4'd15, 4'd8, 4'd14};
        logic [3:0] eb [4] = '{4'd10, 4'd3, 4'd5, 4'd7};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ea[i], eb[i], 2'(i));
            tick;
        end
        total++; if (count !== 3'd4) $display("FAIL fill_count got %0d want 4", count); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready got %b want 0", in_ready); else passed++;
        drive(1'b1, 4'd9, 4'd2, 2'd0);
        tick;
        total++; if (count !== 3'd4 || alu_a !== 4'd7) $display("FAIL fill_drop got count=%0d a=%0d want 4/7", count, alu_a); else passed++;
        // Pop while full with in_valid high: the push must still be refused.
        out_ready = 1'b1;
        tick;
        total++; if (count !== 3'd3) $display("FAIL full_pop_push got count=%0d want 3", count); else passed++;
        drive(1'b0, 4'd0, 4'd0, 2'd0);
        for (int i = 1; i < 4; i++) begin
            total++; if (alu_a !== ea[i] || alu_b !== eb[i] || alu_op !== 2'(i) || out_valid !== 1'b1)
                $display("FAIL fill_drain%0d got a=%0d b=%0d op=%0d want a=%0d b=%0d op=%0d", i, alu_a, alu_b, alu_op, ea[i], eb[i], i);
            else passed++;
            tick;
        end
        out_ready = 1'b0;
        total++; if (count !== 3'd0 || out_valid !== 1'b0) $display("FAIL fill_empty got count=%0d valid=%b want 0/0", count, out_valid); else passed++;
    endtask

    task automatic test_wrap;
        logic [3:0] q [$];
        logic [3:0] nxt;
        out_ready = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            drive(1'b1, 4'(i), 4'(i + 1), 2'(i));
            q.push_back(4'(i));
            tick;
        end
        out_ready = 1'b1;
        for (int i = 3; i <= 8; i++) begin
            nxt = 4'(i);
            drive(1'b1, nxt, 4'(i + 1), 2'(i));
            total++; if (alu_a !== q[0] || alu_b !== q[0] + 4'd1)
                $display("FAIL wrap_head%0d got a=%0d b=%0d want a=%0d b=%0d", i, alu_a, alu_b, q[0], q[0] + 4'd1); else passed++;
            tick;
            void'(q.pop_front());
            q.push_back(nxt);
            total++; if (count !== 3'd2) $display("FAIL wrap_count%0d got %0d want 2", i, count); else passed++;
        end
        drive(1'b0, 4'd0, 4'd0, 2'd0);
        while (q.size() != 0) begin
            total++; if (alu_a !== q[0]) $display("FAIL wrap_drain got a=%0d want %0d", alu_a, q[0]); else passed++;
            tick;
            void'(q.pop_front());
        end
        out_ready = 1'b0;
        total++; if (count !== 3'd0) $display("FAIL wrap_empty got %0d want 0", count); else passed++;
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(10 + i), 4'(i), 2'd1);
            tick;
        end
        total++; if (count !== 3'd3) $display("FAIL flush_pre got %0d want 3", count); else passed++;
        flush = 1'b1;
        drive(1'b1, 4'd13, 4'd4, 2'd2);
        tick;
        flush = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 2'd0);
        total++; if (count !== 3'd0 || out_valid !== 1'b0 || alu_a !== 4'd0)
            $display("FAIL flush_post got count=%0d valid=%b a=%0d want 0/0/0", count, out_valid, alu_a); else passed++;
        drive(1'b1, 4'd5, 4'd6, 2'd3);
        tick;
        drive(1'b0, 4'd0, 4'd0, 2'd0);
        total++; if (count !== 3'd1 || alu_a !== 4'd5 || alu_op !== 2'd3)
            $display("FAIL flush_repush got count=%0d a=%0d op=%0d want 1/5/3", count, alu_a, alu_op); else passed++;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_bypass;
        out_ready = 1'b1;
        drive(1'b1, 4'b1001, 4'd3, 2'd1);
        #1;
`ifdef ALU_CMD_BYPASS_EN
        total++; if (out_valid !== 1'b1 || alu_a !== 4'd9) $display("FAIL bypass_comb got valid=%b a=%0d want 1/9", out_valid, alu_a); else passed++;
`else
        total++; if (out_valid !== 1'b0 || alu_a !== 4'd0) $display("FAIL bypass_comb got valid=%b a=%0d want 0/0", out_valid, alu_a); else passed++;
`endif
        tick;
        drive(1'b0, 4'd0, 4'd0, 2'd0);
`ifdef ALU_CMD_BYPASS_EN
        total++; if (count !== 3'd0) $display("FAIL bypass_count got %0d want 0", count); else passed++;
`else
        total++; if (count !== 3'd1 || alu_a !== 4'd9) $display("FAIL bypass_count got count=%0d a=%0d want 1/9", count, alu_a); else passed++;
`endif
        tick;
        out_ready = 1'b0;
        total++; if (count !== 3'd0) $display("FAIL bypass_end got %0d want 0", count); else passed++;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 2'd0);
        test_reset;
        test_single;
        test_fill;
        test_wrap;
        test_flush;
        test_bypass;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
